cache_port_arbiter: RTL and testbench
=====================================

// Module: cache_port_arbiter
// PURPOSE
// - Shares the single Cache request port between two requesters: port 0 (flash boot loader) and port 1 (CPU/test master).
// - Serializes one read or write at a time: latches the winner's request, drives the cache, waits for completion,
//   returns read data and a one-cycle done pulse. Includes a watchdog so a stuck cache cannot hang a requester.
// PARAMETERS
// - ADDRESS_BITWIDTH  32  width of address on both requester ports and the cache port
// - DATA_BITWIDTH     32  width of data words; write_enable is DATA_BITWIDTH/8 byte lanes
// - TIMEOUT_CYCLES    4096  WAIT cycles before forced completion; 0 disables the watchdog
// PORTS
// - clk                 in   1    cache clock (br_clk_out domain)
// - rst                 in   1    synchronous, active-high reset
// - p0_req / p1_req     in   1    request; hold with fields stable until pN_done
// - pN_address          in   AW   byte address, passed through unchanged
// - pN_data_in          in   DW   write data
// - pN_write_enable     in   DW/8 byte lanes; 0 = read
// - pN_data_out         out  DW   read data, valid in the pN_done cycle, held until next read on that port
// - pN_done             out  1    one-cycle completion pulse
// - cache_address       out  AW   to Cache.address
// - cache_data_in       out  DW   to Cache.data_in
// - cache_write_enable  out  DW/8 to Cache.write_enable
// - cache_data_out      in   DW   from Cache.data_out
// - cache_data_out_ready in  1    from Cache.data_out_ready
// - cache_busy          in   1    from Cache.busy
// - active_port         out  1    port owning the current/last transaction
// - timeout             out  1    sticky; set on watchdog expiry, cleared only by rst
// BEHAVIOUR
// - Reset: all outputs 0; state IDLE; wait counter 0; last_grant=1. rst mid-transaction aborts to IDLE, no done pulse.
// - States: IDLE -> ISSUE -> WAIT -> IDLE. All outputs registered.
// - IDLE: if any req, select winner (fixed priority: port 0 wins ties); register its address/data/write_enable onto
//   cache_*; set active_port, last_grant; -> ISSUE. No req: cache_write_enable stays 0, cache_address holds.
// - ISSUE: hold cache_* one cycle so Cache samples and may raise busy; clear wait counter; -> WAIT.
// - WAIT, completion when !cache_busy and (write: write_enable!=0) or (read: cache_data_out_ready):
//   read -> pN_data_out <= cache_data_out; write -> pN_data_out unchanged; pulse pN_done; cache_write_enable <= 0; -> IDLE.
// - WAIT, no completion: counter++; counter == TIMEOUT_CYCLES-1 (TIMEOUT_CYCLES!=0) -> timeout<=1, pN_done pulse,
//   pN_data_out <= 0 for reads, cache_write_enable <= 0, -> IDLE.
// - Latency: req high in IDLE cycle T -> cache_* valid T+1 -> earliest pN_done at T+3. One transaction in flight.
// - Back-to-back: state is IDLE in the cycle after done; a req still high then is a new request. Requesters drop req
//   in the done cycle to avoid repeats.
// - req dropped before done: transaction still completes and done still pulses (cache access cannot be cancelled).
// - Request fields sampled only in IDLE; changes after grant are ignored.
// - Counter width: clog2(TIMEOUT_CYCLES)+1, no wrap before expiry.
// CONFIGURATION
// - CACHE_PORT_ARBITER_ROUND_ROBIN_EN defined: on simultaneous req in IDLE, grant the port != last_grant
//   (first tie after reset -> port 0). Single req always granted regardless.
// - Not defined: fixed priority, port 0 always wins ties (port 1 can starve while port 0 streams).
// TESTING
// - Single read p1 addr 0x4, cache returns 0x68676665 after busy 5 cycles -> p1_done 1 cycle, p1_data_out=0x68676665.
// - p0 write addr 0x0 data 0x64636261 we=4'b1111, busy 3 cycles -> cache_* hold values, p0_done once, we back to 0.
// - p0 and p1 req same cycle, both held 4 txns -> fixed: four p0 grants, 0 p1; ROUND_ROBIN_EN: order 0,1,0,1.
// - TIMEOUT_CYCLES=16, cache_busy stuck 1 on a p1 read -> p1_done at WAIT cycle 16, p1_data_out=0, timeout=1 sticky.
// - rst asserted in WAIT -> next cycle all outputs 0, no done; new p0 read after rst completes normally.
// - Min latency: busy never asserted, data_out_ready=1 -> done exactly 3 cycles after req sampled in IDLE.

Source files
------------

// File: rtl/cache_port_arbiter.sv
// Two-requester arbiter in front of the single Cache port: one transaction in flight, watchdog-bounded.
// Optional build macro CACHE_PORT_ARBITER_ROUND_ROBIN_EN alternates grants on ties instead of fixed priority to port 0.
module cache_port_arbiter #(
  parameter int ADDRESS_BITWIDTH = 32,
  parameter int DATA_BITWIDTH    = 32,
  parameter int TIMEOUT_CYCLES   = 4096
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          p0_req,
  input  logic [ADDRESS_BITWIDTH-1:0]   p0_address,
  input  logic [DATA_BITWIDTH-1:0]      p0_data_in,
  input  logic [DATA_BITWIDTH/8-1:0]    p0_write_enable,
  output logic [DATA_BITWIDTH-1:0]      p0_data_out,
  output logic                          p0_done,
  input  logic                          p1_req,
  input  logic [ADDRESS_BITWIDTH-1:0]   p1_address,
  input  logic [DATA_BITWIDTH-1:0]      p1_data_in,
  input  logic [DATA_BITWIDTH/8-1:0]    p1_write_enable,
  output logic [DATA_BITWIDTH-1:0]      p1_data_out,
  output logic                          p1_done,
  output logic [ADDRESS_BITWIDTH-1:0]   cache_address,
  output logic [DATA_BITWIDTH-1:0]      cache_data_in,
  output logic [DATA_BITWIDTH/8-1:0]    cache_write_enable,
  input  logic [DATA_BITWIDTH-1:0]      cache_data_out,
  input  logic                          cache_data_out_ready,
  input  logic                          cache_busy,
  output logic                          active_port,
  output logic                          timeout
);

  localparam int WE_W = DATA_BITWIDTH / 8;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int unsigned CNT_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CNT_LAST);
  localparam bit WDOG_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t                      state_q, state_d;
  logic [ADDRESS_BITWIDTH-1:0] cache_address_q, cache_address_d;
  logic [DATA_BITWIDTH-1:0]    cache_data_in_q, cache_data_in_d;
  logic [WE_W-1:0]             cache_we_q, cache_we_d;
  logic [DATA_BITWIDTH-1:0]    p0_data_q, p0_data_d;
  logic [DATA_BITWIDTH-1:0]    p1_data_q, p1_data_d;
  logic                        p0_done_q, p0_done_d;
  logic                        p1_done_q, p1_done_d;
  logic                        active_port_q, active_port_d;
  logic                        last_grant_q, last_grant_d;
  logic                        timeout_q, timeout_d;
  logic [CNT_W-1:0]            wait_cnt_q, wait_cnt_d;

  logic any_req;
  logic grant;
  logic is_write;
  logic complete;
  logic expired;

  assign any_req  = p0_req | p1_req;
  assign is_write = |cache_we_q;
  assign complete = !cache_busy && (is_write || cache_data_out_ready);
  assign expired  = WDOG_EN && (wait_cnt_q == CNT_MAX);

`ifdef CACHE_PORT_ARBITER_ROUND_ROBIN_EN
  // On a tie the port that did not win last time goes first.
  assign grant = (p0_req && p1_req) ? ~last_grant_q : p1_req;
`else
  assign grant = ~p0_req;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      cache_address_q <= '0;
      cache_data_in_q <= '0;
      cache_we_q      <= '0;
      p0_data_q       <= '0;
      p1_data_q       <= '0;
      p0_done_q       <= 1'b0;
      p1_done_q       <= 1'b0;
      active_port_q   <= 1'b0;
      last_grant_q    <= 1'b1;
      timeout_q       <= 1'b0;
      wait_cnt_q      <= '0;
    end else begin
      state_q         <= state_d;
      cache_address_q <= cache_address_d;
      cache_data_in_q <= cache_data_in_d;
      cache_we_q      <= cache_we_d;
      p0_data_q       <= p0_data_d;
      p1_data_q       <= p1_data_d;
      p0_done_q       <= p0_done_d;
      p1_done_q       <= p1_done_d;
      active_port_q   <= active_port_d;
      last_grant_q    <= last_grant_d;
      timeout_q       <= timeout_d;
      wait_cnt_q      <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    cache_address_d = cache_address_q;
    cache_data_in_d = cache_data_in_q;
    cache_we_d      = cache_we_q;
    p0_data_d       = p0_data_q;
    p1_data_d       = p1_data_q;
    p0_done_d       = 1'b0;
    p1_done_d       = 1'b0;
    active_port_d   = active_port_q;
    last_grant_d    = last_grant_q;
    timeout_d       = timeout_q;
    wait_cnt_d      = wait_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          cache_address_d = grant ? p1_address      : p0_address;
          cache_data_in_d = grant ? p1_data_in      : p0_data_in;
          cache_we_d      = grant ? p1_write_enable : p0_write_enable;
          active_port_d   = grant;
          last_grant_d    = grant;
          state_d         = S_ISSUE;
        end
      end

      S_ISSUE: begin
        wait_cnt_d = '0;
        state_d    = S_WAIT;
      end

      S_WAIT: begin
        if (complete || expired) begin
          // A watchdog-forced read returns zero rather than whatever the cache drives.
          if (!is_write) begin
            if (active_port_q) p1_data_d = complete ? cache_data_out : '0;
            else               p0_data_d = complete ? cache_data_out : '0;
          end
          if (!complete) timeout_d = 1'b1;
          p0_done_d  = ~active_port_q;
          p1_done_d  = active_port_q;
          cache_we_d = '0;
          state_d    = S_IDLE;
        end else if (WDOG_EN) begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign cache_address      = cache_address_q;
  assign cache_data_in      = cache_data_in_q;
  assign cache_write_enable = cache_we_q;
  assign p0_data_out        = p0_data_q;
  assign p1_data_out        = p1_data_q;
  assign p0_done            = p0_done_q;
  assign p1_done            = p1_done_q;
  assign active_port        = active_port_q;
  assign timeout            = timeout_q;

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Scoreboard bench for cache_port_arbiter: directed transactions push expectations, a done monitor pops and compares.
module tb_cache_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int WEW = DW / 8;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst;
  logic p0_req, p1_req;
  logic [AW-1:0] p0_address, p1_address;
  logic [DW-1:0] p0_data_in, p1_data_in;
  logic [WEW-1:0] p0_write_enable, p1_write_enable;
  logic [DW-1:0] p0_data_out, p1_data_out;
  logic p0_done, p1_done;
  logic [AW-1:0] cache_address;
  logic [DW-1:0] cache_data_in;
  logic [WEW-1:0] cache_write_enable;
  logic [DW-1:0] cache_data_out;
  logic cache_data_out_ready, cache_busy;
  logic active_port, timeout;
  logic c_busy, c_ready;

  always #5 clk = ~clk;

  cache_port_arbiter #(.ADDRESS_BITWIDTH(AW), .DATA_BITWIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_address(p0_address), .p0_data_in(p0_data_in),
    .p0_write_enable(p0_write_enable), .p0_data_out(p0_data_out), .p0_done(p0_done),
    .p1_req(p1_req), .p1_address(p1_address), .p1_data_in(p1_data_in),
    .p1_write_enable(p1_write_enable), .p1_data_out(p1_data_out), .p1_done(p1_done),
    .cache_address(cache_address), .cache_data_in(cache_data_in),
    .cache_write_enable(cache_write_enable), .cache_data_out(cache_data_out),
    .cache_data_out_ready(cache_data_out_ready), .cache_busy(cache_busy),
    .active_port(active_port), .timeout(timeout)
  );

  // Cache stand-in: fixed contents per address, handshake driven by the test sequence.
  function automatic logic [DW-1:0] lookup(input logic [AW-1:0] a);
    case (a)
      32'h4:   lookup = 32'h68676665;
      32'h8:   lookup = 32'h0BADF00D;
      32'h10:  lookup = 32'h11112222;
      32'h14:  lookup = 32'h33334444;
      32'h20:  lookup = 32'hCAFEF00D;
      default: lookup = 32'hA5A5A5A5;
    endcase
  endfunction

  assign cache_data_out       = lookup(cache_address);
  assign cache_busy           = c_busy;
  assign cache_data_out_ready = c_ready;

  typedef struct packed {
    logic          port;
    logic [DW-1:0] data;
    logic          tmo;
    int            cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (p0_done || p1_done) begin
      if (p0_done && p1_done) begin
        checks++; errors++;
        $display("FAIL both_done: got both done pulses expected one (cycle %0d)", cyc);
      end else if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done: port %0d done got 1 expected 0 (cycle %0d)", p1_done, cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("done_port", 64'(p1_done), 64'(mon_e.port));
        chk("active_port", 64'(active_port), 64'(mon_e.port));
        chk("data_out", 64'(mon_e.port ? p1_data_out : p0_data_out), 64'(mon_e.data));
        chk("timeout", 64'(timeout), 64'(mon_e.tmo));
        if (mon_e.cyc >= 0) chk("done_cycle", 64'(cyc), 64'(mon_e.cyc));
      end
    end
  end

  task automatic drive(input logic port, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [WEW-1:0] we);
    if (port) begin
      p1_req = 1'b1; p1_address = a; p1_data_in = d; p1_write_enable = we;
    end else begin
      p0_req = 1'b1; p0_address = a; p0_data_in = d; p0_write_enable = we;
    end
  endtask

  task automatic expect_txn(input logic port, input logic [DW-1:0] data, input logic tmo, input int c);
    exp_t e;
    e.port = port; e.data = data; e.tmo = tmo; e.cyc = c;
    sb.push_back(e);
  endtask

  // Requester side: drop req in the done cycle so no repeat is issued.
  task automatic wait_done(input logic port, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (port ? p1_done : p0_done) begin
        seen = 1'b1;
        break;
      end
    end
    if (port) p1_req = 1'b0; else p0_req = 1'b0;
    if (!seen) begin
      checks++; errors++;
      $display("FAIL wait_done: port %0d got no done expected done within %0d cycles", port, budget);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cache_address"}, 64'(cache_address), 64'h0);
    chk({tag, "_cache_data_in"}, 64'(cache_data_in), 64'h0);
    chk({tag, "_cache_we"}, 64'(cache_write_enable), 64'h0);
    chk({tag, "_p0_done"}, 64'(p0_done), 64'h0);
    chk({tag, "_p1_done"}, 64'(p1_done), 64'h0);
    chk({tag, "_p0_data_out"}, 64'(p0_data_out), 64'h0);
    chk({tag, "_p1_data_out"}, 64'(p1_data_out), 64'h0);
    chk({tag, "_active_port"}, 64'(active_port), 64'h0);
    chk({tag, "_timeout"}, 64'(timeout), 64'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation got stuck expected completion");
    $fatal(1, "global timeout");
  end

  initial begin
    int n;
    rst = 1'b1;
    p0_req = 1'b0; p0_address = '0; p0_data_in = '0; p0_write_enable = '0;
    p1_req = 1'b0; p1_address = '0; p1_data_in = '0; p1_write_enable = '0;
    c_busy = 1'b0; c_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // p1 read, cache busy for 5 cycles
    c_ready = 1'b0;
    drive(1'b1, 32'h4, '0, '0);
    expect_txn(1'b1, 32'h68676665, 1'b0, cyc + 7);
    @(negedge clk);
    c_busy = 1'b1;
    repeat (5) @(negedge clk);
    c_busy = 1'b0; c_ready = 1'b1;
    wait_done(1'b1, 10);
    @(negedge clk);

    // Both ports request and hold for four transactions
`ifdef CACHE_PORT_ARBITER_ROUND_ROBIN_EN
    expect_txn(1'b0, 32'h11112222, 1'b0, -1);
    expect_txn(1'b1, 32'h33334444, 1'b0, -1);
    expect_txn(1'b0, 32'h11112222, 1'b0, -1);
    expect_txn(1'b1, 32'h33334444, 1'b0, -1);
`else
    for (int i = 0; i < 4; i++) expect_txn(1'b0, 32'h11112222, 1'b0, -1);
`endif
    drive(1'b0, 32'h10, '0, '0);
    drive(1'b1, 32'h14, '0, '0);
    n = 0;
    for (int i = 0; i < 100 && n < 4; i++) begin
      @(negedge clk);
      if (p0_done || p1_done) n++;
    end
    p0_req = 1'b0; p1_req = 1'b0;
    chk("arb_txn_count", 64'(n), 64'd4);
    repeat (4) @(negedge clk);

    // Minimum latency p0 read
    drive(1'b0, 32'h8, '0, '0);
    expect_txn(1'b0, 32'h0BADF00D, 1'b0, cyc + 3);
    wait_done(1'b0, 10);
    @(negedge clk);

    // p0 write, busy 3 cycles; read data on p0 must not change
    drive(1'b0, 32'h0, 32'h64636261, 4'b1111);
    expect_txn(1'b0, 32'h0BADF00D, 1'b0, cyc + 5);
    @(negedge clk);
    chk("wr_issue_addr", 64'(cache_address), 64'h0);
    chk("wr_issue_data", 64'(cache_data_in), 64'h64636261);
    chk("wr_issue_we", 64'(cache_write_enable), 64'hF);
    c_busy = 1'b1; c_ready = 1'b0;
    @(negedge clk);
    chk("wr_hold_we", 64'(cache_write_enable), 64'hF);
    chk("wr_hold_data", 64'(cache_data_in), 64'h64636261);
    repeat (2) @(negedge clk);
    c_busy = 1'b0;
    wait_done(1'b0, 10);
    chk("wr_done_we", 64'(cache_write_enable), 64'h0);
    c_ready = 1'b1;
    @(negedge clk);

    // Stuck cache on a p1 read: watchdog forces completion with zero data
    chk("pre_timeout", 64'(timeout), 64'h0);
    drive(1'b1, 32'h20, '0, '0);
    expect_txn(1'b1, 32'h0, 1'b1, cyc + 18);
    c_busy = 1'b1; c_ready = 1'b0;
    wait_done(1'b1, 40);
    c_busy = 1'b0; c_ready = 1'b1;
    @(negedge clk);

    // Timeout flag stays set across a normal transaction
    drive(1'b0, 32'h10, '0, '0);
    expect_txn(1'b0, 32'h11112222, 1'b1, cyc + 3);
    wait_done(1'b0, 10);
    repeat (2) @(negedge clk);
    chk("timeout_sticky", 64'(timeout), 64'h1);

    // Reset in the middle of WAIT aborts without a done pulse
    drive(1'b0, 32'h14, '0, '0);
    c_busy = 1'b1; c_ready = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1; p0_req = 1'b0;
    @(negedge clk);
    chk_all_zero("midrst");
    rst = 1'b0; c_busy = 1'b0; c_ready = 1'b1;
    repeat (3) @(negedge clk);

    // Fresh p0 read after reset
    drive(1'b0, 32'h4, '0, '0);
    expect_txn(1'b0, 32'h68676665, 1'b0, cyc + 3);
    wait_done(1'b0, 10);
    repeat (3) @(negedge clk);

    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
